// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier (signed/unsigned) with start/busy/done handshake.
// Optional MULT_EARLY_ZERO_EN: a zero operand skips iteration and completes one cycle after accept.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last product
// RUN   | one Booth iteration per clock until count reaches 1
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH+1:0] a_reg;
    logic [WIDTH+1:0] m_reg;
    logic [WIDTH:0]   q_reg;
    logic             qm1;
    logic [CW-1:0]    count;

    logic [WIDTH+1:0] a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH+1:0] a_sum;
    logic [WIDTH+1:0] a_next;
    logic [WIDTH:0]   q_next;
    logic             accept;
    logic             idle_free;
    logic             zero_hit;
    logic             zero_fire;

    always_comb begin
        a_ext = signed_mode ? {{2{op_a[WIDTH-1]}}, op_a} : {2'b00, op_a};
        b_ext = signed_mode ? {op_b[WIDTH-1], op_b} : {1'b0, op_b};

        a_sum = a_reg;
        case ({q_reg[0], qm1})
            2'b10:   a_sum = a_reg - m_reg;
            2'b01:   a_sum = a_reg + m_reg;
            default: a_sum = a_reg;
        endcase

        // arithmetic right shift of {A,Q,q_-1}; q_-1 takes the old Q0
        a_next = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
        q_next = {a_sum[0], q_reg[WIDTH:1]};
    end

`ifdef MULT_EARLY_ZERO_EN
    logic zero_pend;

    assign idle_free = !zero_pend;
    assign zero_hit  = accept && ((op_a == '0) || (op_b == '0));
    assign zero_fire = zero_pend;

    always_ff @(posedge clk) begin
        if (reset) zero_pend <= 1'b0;
        else       zero_pend <= zero_hit;
    end
`else
    assign idle_free = 1'b1;
    assign zero_hit  = 1'b0;
    assign zero_fire = 1'b0;
`endif

    assign accept = (state == IDLE) && start && idle_free;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            a_reg <= '0;
            m_reg <= '0;
            q_reg <= '0;
            qm1   <= 1'b0;
            count <= '0;
        end else begin
            done <= 1'b0;
            if (zero_fire) begin
                hi   <= '0;
                lo   <= '0;
                done <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept && !zero_hit) begin
                        a_reg <= '0;
                        m_reg <= a_ext;
                        q_reg <= b_ext;
                        qm1   <= 1'b0;
                        count <= CW'(WIDTH + 1);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_next;
                    q_reg <= q_next;
                    qm1   <= q_reg[0];
                    count <= count - 1'b1;
                    if (count == CW'(1)) begin
                        // product is the low 2*WIDTH bits of {A,Q}
                        hi    <= {a_next[WIDTH-2:0], q_next[WIDTH]};
                        lo    <= q_next[WIDTH-1:0];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
